// File: rtl/alu_muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes and FSM states.
package alu_muldiv_pkg;

  localparam int MD_OP_WIDTH = 2;

  typedef enum logic [MD_OP_WIDTH-1:0] {
    MD_OP_MULTU = 2'b00,
    MD_OP_MULT  = 2'b01,
    MD_OP_DIVU  = 2'b10,
    MD_OP_DIV   = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_CALC = 2'b01,
    MD_ST_FIX  = 2'b10,
    MD_ST_DONE = 2'b11
  } md_state_e;

endpackage

// File: rtl/alu_muldiv_md_iter_step.sv
// One radix-2 iteration: shift-add multiply step (mode=0) or restoring divide step (mode=1).
module md_iter_step
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_s;
  logic [WIDTH+1:0] diff;
  logic             unused_diff;

  assign unused_diff = diff[WIDTH];

  always_comb begin
    sum   = {1'b0, acc_hi} + {1'b0, opnd};
    rem_s = {acc_hi, acc_lo[WIDTH-1]};
    diff  = {1'b0, rem_s} - {2'b00, opnd};
    nxt_hi = acc_hi;
    nxt_lo = acc_lo;
    if (mode) begin
      // A non-negative trial result is always below the divisor, so it fits WIDTH bits.
      if (!diff[WIDTH+1]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_s[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else if (acc_lo[0]) begin
      {nxt_hi, nxt_lo} = {sum, acc_lo[WIDTH-1:1]};
    end else begin
      {nxt_hi, nxt_lo} = {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Iterative mult/multu/div/divu unit with HI/LO registers and start/busy/done handshake.
// Signed op handling is built only when ALU_MULDIV_SIGNED_EN is defined.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [MD_OP_WIDTH-1:0] op,
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  input  logic                   hi_we,
  input  logic                   lo_we,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       hi,
  output logic [WIDTH-1:0]       lo,
  output logic                   busy,
  output logic                   done,
  output logic                   div_zero
);

  md_state_e        state;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] res_hi, res_lo, quo, rem, dz_hi;
  logic [2*WIDTH-1:0] prod;
  logic             is_div, op_div;

  assign op_div = (op == MD_OP_DIVU) || (op == MD_OP_DIV);

`ifdef ALU_MULDIV_SIGNED_EN
  logic sgn, neg_res, neg_rem;

  assign sgn   = op[0];
  assign a_mag = (sgn && a[WIDTH-1]) ? -a : a;
  assign b_mag = (sgn && b[WIDTH-1]) ? -b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (start && !busy) begin
      neg_res <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_rem <= sgn && a[WIDTH-1];
    end
  end
`else
  logic unused_op0;

  assign unused_op0 = op[0];
  assign a_mag      = a;
  assign b_mag      = b;
`endif

  md_iter_step #(.WIDTH(WIDTH)) u_step (
    .mode   (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // Divide-by-zero skips iteration, so acc_lo still holds |a| and the remainder
  // sign rule restores the original dividend for HI.
  always_comb begin
    prod  = {acc_hi, acc_lo};
    quo   = acc_lo;
    rem   = acc_hi;
    dz_hi = acc_lo;
`ifdef ALU_MULDIV_SIGNED_EN
    if (neg_res) begin
      prod = -prod;
      quo  = -quo;
    end
    if (neg_rem) begin
      rem   = -rem;
      dz_hi = -dz_hi;
    end
`endif
    if (!is_div) begin
      {res_hi, res_lo} = prod;
    end else if (div_zero) begin
      res_hi = dz_hi;
      res_lo = '1;
    end else begin
      res_hi = rem;
      res_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= MD_ST_IDLE;
      counter  <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      case (state)
        MD_ST_IDLE, MD_ST_DONE: begin
          if (start) begin
            is_div   <= op_div;
            acc_hi   <= '0;
            acc_lo   <= a_mag;
            opnd     <= b_mag;
            counter  <= CNT_W'(WIDTH);
            busy     <= 1'b1;
            div_zero <= 1'b0;
            state    <= MD_ST_CALC;
          end else begin
            state <= MD_ST_IDLE;
          end
        end
        MD_ST_CALC: begin
          if (is_div && (opnd == '0)) begin
            div_zero <= 1'b1;
            state    <= MD_ST_FIX;
          end else begin
            acc_hi  <= nxt_hi;
            acc_lo  <= nxt_lo;
            counter <= counter - CNT_W'(1);
            if (counter == CNT_W'(1)) state <= MD_ST_FIX;
          end
        end
        MD_ST_FIX: begin
          hi    <= res_hi;
          lo    <= res_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= MD_ST_DONE;
        end
        default: state <= MD_ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: driver pushes model results, monitor checks on done.
module tb_alu_muldiv;
  import alu_muldiv_pkg::*;

  localparam int W = 32;
`ifdef ALU_MULDIV_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic [W-1:0] hi, lo;
  logic         busy, done, div_zero;

  alu_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
    int unsigned  lat;
    int unsigned  t0;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           n_pass = 0, n_total = 0;
  logic [W-1:0] model_hi = '0, model_lo = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endfunction

  // Reference model straight from the arithmetic definitions.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    bit           s;
    int           sx, sy;
    longint       p;
    logic [63:0]  pv;
    s = SGN && o[0];
    sx = x;
    sy = y;
    e.dz = 1'b0;
    e.lat = 33;
    e.t0 = 0;
    if (!o[1]) begin
      if (s) begin
        p = longint'(sx) * longint'(sy);
        pv = p;
      end else begin
        pv = {32'b0, x} * {32'b0, y};
      end
      {e.hi, e.lo} = pv;
    end else if (y == 0) begin
      e.lo = '1;
      e.hi = x;
      e.dz = 1'b1;
      e.lat = 2;
    end else if (s) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
        e.lo = x;
        e.hi = '0;
      end else begin
        e.lo = sx / sy;
        e.hi = sx % sy;
      end
    end else begin
      e.lo = x / y;
      e.hi = x % y;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sbq.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        mon_e = sbq.pop_front();
        check("hi", hi, mon_e.hi);
        check("lo", lo, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
        check("latency", cyc - mon_e.t0 - 1, mon_e.lat);
      end
    end
  end

  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    exp_t         e;
    int           k;
    logic [W-1:0] prev_hi;
    k = 0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (busy) check("busy_timeout", 1, 0);
    e = model(o, x, y);
    e.t0 = cyc;
    prev_hi = model_hi;
    model_hi = e.hi;
    model_lo = e.lo;
    op = o;
    a = x;
    b = y;
    start = 1'b1;
    sbq.push_back(e);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("dz_cleared_on_start", div_zero, 0);
    if (poke) begin
      start = 1'b1;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      hi_we = 1'b1;
      wdata = 32'hA5A5_A5A5;
      @(negedge clk);
      start = 1'b0;
      hi_we = 1'b0;
      check("mthi_while_busy", hi, prev_hi);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (sbq.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (sbq.size() != 0) begin
      check("done_timeout", 0, 1);
      sbq.delete();
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'd1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_div_zero", div_zero, 0);
    rst_n = 1'b1;

    do_op(MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); wait_done();
    do_op(MD_OP_MULT,  32'hFFFF_FFF9, 32'd6, 1'b0);         wait_done();
    do_op(MD_OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b0);         wait_done();
    do_op(MD_OP_DIVU,  32'd100, 32'd7, 1'b0);               wait_done();
    do_op(MD_OP_DIVU,  32'h1234, 32'd0, 1'b0);              wait_done();
    do_op(MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0); wait_done();
    do_op(MD_OP_DIV,   32'hFFFF_FFFB, 32'd0, 1'b0);         wait_done();
    do_op(MD_OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
    do_op(MD_OP_DIVU,  32'd9, 32'd0, 1'b0);
    do_op(MD_OP_DIV,   32'd45, 32'hFFFF_FFF9, 1'b0);        wait_done();

    // Busy rules: ignored start and mthi mid-op, then mtlo once idle.
    do_op(MD_OP_MULTU, 32'd1000, 32'd3, 1'b1);              wait_done();
    lo_we = 1'b1;
    wdata = 32'h5;
    @(negedge clk);
    lo_we = 1'b0;
    model_lo = 32'h5;
    check("mtlo_idle", lo, 32'h5);
    hi_we = 1'b1;
    wdata = 32'h1357_9BDF;
    @(negedge clk);
    hi_we = 1'b0;
    model_hi = 32'h1357_9BDF;
    check("mthi_idle", hi, 32'h1357_9BDF);

    // Reset in the middle of a multiply.
    do_op(MD_OP_MULT, 32'd12345, 32'd678, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    sbq.delete();
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    do_op(MD_OP_DIVU, 32'd1000, 32'd33, 1'b0);              wait_done();

    for (int i = 0; i < 40; i++) begin
      do_op(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 2) != 0) wait_done();
    end
    wait_done();
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
